sad_boss_tracker: RTL
=====================

Name: sad_boss_tracker

Overview:
- Consumer at the far end of the SAD pipeline. Accepts one candidate per cycle from the SAD5 stage: index, two 14-bit partial sums and the TriggerBoss qualifier.
- Completes the final add (partial1 + partial2) and tracks the minimum SAD and its index over a search window of N candidates.
- Reports the best match with a one-cycle done pulse. This is the "boss" the pipeline triggers.

Parameters:
- IDX_W, 16, candidate index width
- PART_W, 14, width of each partial SAD from the SAD5 stage
- CNT_W, 16, width of the candidate counter and num_cand

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a search window (honoured in IDLE only)
- num_cand  in  CNT_W  candidates in the window; sampled on the accepted start
- SAD5_Index  in  IDX_W  candidate index
- SAD5_TriggerBoss  in  1  candidate valid qualifier
- SAD5_input1  in  PART_W  partial SAD 1
- SAD5_input2  in  PART_W  partial SAD 2
- busy  out  1  high while in SEARCH or DRAIN
- done  out  1  one-cycle pulse when results are final
- best_index  out  IDX_W  index of the minimum SAD
- best_sad  out  PART_W+1  minimum SAD value
- found  out  1  at least one candidate was processed in the last window

Behaviour:
- Reset: all outputs 0, state IDLE, pipeline valid cleared, counter 0, internal min register all-ones. Reset asserted mid-search abandons the search; no done pulse is produced.
- Stage A (registered):
  - sum_a = SAD5_input1 + SAD5_input2, zero-extended to PART_W+1 bits, so no overflow is possible.
  - idx_a and vld_a are registered alongside sum_a.
  - vld_a = SAD5_TriggerBoss && state==SEARCH && remaining>0. Candidates arriving in IDLE, DRAIN or DONE are dropped.
- Stage B (compare):
  - If vld_a and (first candidate of the window, or sum_a < min_sad), load min_sad=sum_a and min_idx=idx_a.
  - The comparison is strict less-than, so on a tie the earlier (first-accepted) candidate is kept.
- FSM states: IDLE, SEARCH, DRAIN, DONE.
  - IDLE: on start, latch remaining=num_cand, set min_sad to all-ones, clear first/found flags, then go to SEARCH. If num_cand==0, go directly to DONE.
  - SEARCH: each accepted candidate decrements remaining. When the accepted candidate brings remaining to 0, go to DRAIN. Gaps in TriggerBoss are allowed and there is no timeout.
  - DRAIN: one cycle that lets stage B absorb the last stage-A entry, then go to DONE.
  - DONE: one cycle. done=1; best_index, best_sad and found are updated from min_idx, min_sad and the found flag. Then go to IDLE.
  - start is ignored outside IDLE, with no restart.
- Latency: if the last candidate is presented in cycle T, done is high in cycle T+3. Outputs are registered.
- Output hold: best_index, best_sad and found hold their values until the next DONE. They are not cleared by start.
- num_cand==0: done pulses 2 cycles after start, with found=0, best_sad=all-ones and best_index=0.
- busy: 1 in SEARCH and DRAIN, 0 in IDLE and DONE.
- Maximum window: 2^CNT_W−1 candidates. The counter never wraps, because acceptance stops at remaining==0.

Decomposition:
- Shared package sad_pkg holds:
  - the state enum (IDLE, SEARCH, DRAIN, DONE)
  - the width constants IDX_W, PART_W and SAD_W=PART_W+1
  - SAD_MAX = all-ones of SAD_W
- One natural sub-module: sad_final_add, the stage-A registered adder with index and valid passthrough. It is reusable by any other SAD consumer. The FSM and comparator stay in the top level.

Test Plan:
- Basic window:
  - Stimulus: start with num_cand=4. Candidates, each given as (idx, in1, in2): (0,100,50), (1,20,10), (2,300,0), (3,40,40).
  - Response: done at T+3 after idx3; best_index=1, best_sad=30, found=1.
- Tie and gaps:
  - Stimulus: num_cand=3 with sums 500, 200, 200 at idx 7, 8, 9. TriggerBoss is low for 2 cycles between each candidate.
  - Response: best_index=8, best_sad=200.
- Width extremes:
  - Stimulus: in1=in2=16383 (sum 32766) followed by in1=0, in2=0; num_cand=2.
  - Response: best_sad=0 with the second index. A single-candidate window holding 32766 reports best_sad=32766 with no overflow.
- Dropped inputs:
  - Stimulus: TriggerBoss pulses while IDLE, and 5 valid candidates are sent into a num_cand=3 window.
  - Response: only the first 3 are considered, and done pulses once. A start issued while busy is ignored and busy stays high.
- Zero window:
  - Stimulus: start with num_cand=0.
  - Response: done 2 cycles later with found=0, best_sad=32767 and best_index=0; busy never asserts.
- Reset mid-search:
  - Stimulus: assert rst_n=0 after 2 of 4 candidates have been accepted.
  - Response: all outputs are 0 immediately (asynchronously); no done pulse. A subsequent full window behaves as in the basic-window case.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and widths for the SAD pipeline's final stage.
// Holds the tracker state encoding plus default index/partial/sum widths.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } sad_state_e;

  localparam int IDX_W  = 16;
  localparam int PART_W = 14;
  localparam int SAD_W  = PART_W + 1;

  localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

endpackage

// File: rtl/sad_final_add.sv
// Final SAD adder: registers partial1 + partial2 with index and valid alongside.
// Latency 1 cycle; no backpressure, one candidate accepted every cycle.
// The sum is one bit wider than the partials, so it cannot overflow.
module sad_final_add #(
  parameter int IDX_W  = 16,
  parameter int PART_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [PART_W-1:0] in1,
  input  logic [PART_W-1:0] in2,
  output logic              vld_a,
  output logic [IDX_W-1:0]  idx_a,
  output logic [PART_W:0]   sum_a
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a <= 1'b0;
      idx_a <= '0;
      sum_a <= '0;
    end else begin
      vld_a <= in_vld;
      idx_a <= in_idx;
      sum_a <= {1'b0, in1} + {1'b0, in2};
    end
  end

endmodule

// File: rtl/sad_boss_tracker.sv
// Minimum-SAD tracker over a window of num_cand candidates; reports the best match.
// Latency: done is high 3 cycles after the last candidate; no backpressure, extras dropped.
// Outputs are registered and hold until the next window completes.
module sad_boss_tracker #(
  parameter int IDX_W  = 16,
  parameter int PART_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cand,
  input  logic [IDX_W-1:0]  SAD5_Index,
  input  logic              SAD5_TriggerBoss,
  input  logic [PART_W-1:0] SAD5_input1,
  input  logic [PART_W-1:0] SAD5_input2,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  best_index,
  output logic [PART_W:0]   best_sad,
  output logic              found
);

  import sad_pkg::*;

  localparam int SAD_W = PART_W + 1;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SEARCH = SEARCH;
  localparam logic [1:0] ST_DRAIN  = DRAIN;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             start_ok;

  logic             vld_a;
  logic [IDX_W-1:0] idx_a;
  logic [SAD_W-1:0] sum_a;

  logic [SAD_W-1:0] min_sad;
  logic [IDX_W-1:0] min_idx;
  logic             found_r;

  assign accept   = SAD5_TriggerBoss && (state == ST_SEARCH) && (remaining != '0);
  assign start_ok = start && (state == ST_IDLE);
  assign busy     = (state == ST_SEARCH) || (state == ST_DRAIN);

  sad_final_add #(
    .IDX_W  (IDX_W),
    .PART_W (PART_W)
  ) u_final_add (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (accept),
    .in_idx (SAD5_Index),
    .in1    (SAD5_input1),
    .in2    (SAD5_input2),
    .vld_a  (vld_a),
    .idx_a  (idx_a),
    .sum_a  (sum_a)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      done       <= 1'b0;
      best_index <= '0;
      best_sad   <= '0;
      found      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= num_cand;
            state     <= (num_cand == '0) ? ST_DONE : ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= ST_DRAIN;
          end
        end
        // Stage B absorbs the final stage-A entry during this cycle.
        ST_DRAIN: state <= ST_DONE;
        ST_DONE: begin
          done       <= 1'b1;
          best_index <= min_idx;
          best_sad   <= min_sad;
          found      <= found_r;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strict less-than keeps the earliest candidate on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_sad <= {SAD_W{1'b1}};
      min_idx <= '0;
      found_r <= 1'b0;
    end else if (start_ok) begin
      min_sad <= {SAD_W{1'b1}};
      min_idx <= '0;
      found_r <= 1'b0;
    end else if (vld_a) begin
      found_r <= 1'b1;
      if (!found_r || (sum_a < min_sad)) begin
        min_sad <= sum_a;
        min_idx <= idx_a;
      end
    end
  end

endmodule
